// File: rtl/uart_tx_fifo.sv
// UART transmitter with a circular transmit FIFO and an IDLE/START/DATA/PARITY/STOP serialiser.
// Define UART_TX_PARITY_EN to add the parity_mode port and the PARITY state.
//
// state    | meaning
// S_IDLE   | line idle (txd=1), waiting for a tick with the FIFO non-empty
// S_START  | start bit (txd=0)
// S_DATA   | data bits, LSB first, indexed by bit_idx_q
// S_PARITY | even/odd/mark bit over the latched character (parity build only)
// S_STOP   | stop bit(s) (txd=1), stop_cnt_q counts down to the last one
module uart_tx_fifo #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int STOP_BITS  = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          baud_t_enable,
    input  logic                          wr_en,
    input  logic [DATA_W-1:0]             wr_data,
`ifdef UART_TX_PARITY_EN
    input  logic [1:0]                    parity_mode,
`endif
    output logic                          txd,
    output logic                          tbr,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int IW = $clog2(DATA_W);
    localparam logic [1:0]    STOP_LAST = 2'(STOP_BITS - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]     count_q;
    logic              overflow_q;
    logic              push, pop, fifo_empty, fifo_full;

    state_t            state_q, state_d;
    logic [IW-1:0]     bit_idx_q, bit_idx_d;
    logic [1:0]        stop_cnt_q, stop_cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              txd_q, txd_d;
`ifdef UART_TX_PARITY_EN
    logic [1:0]        par_mode_q, par_mode_d;
    logic              par_bit;
`endif

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
    // A full FIFO still accepts a write in the same cycle the serialiser pops.
    assign push       = wr_en && (!fifo_full || pop);

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            overflow_q <= wr_en && !push;
        end
    end

`ifdef UART_TX_PARITY_EN
    always_comb begin
        par_bit = 1'b0;
        case (par_mode_q)
            2'd1:    par_bit = ^shift_q;
            2'd2:    par_bit = ~^shift_q;
            2'd3:    par_bit = 1'b1;
            default: par_bit = 1'b0;
        endcase
    end
`endif

    always_comb begin
        state_d    = state_q;
        bit_idx_d  = bit_idx_q;
        stop_cnt_d = stop_cnt_q;
        shift_d    = shift_q;
        pop        = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_mode_d = par_mode_q;
`endif
        if (baud_t_enable) begin
            case (state_q)
                S_IDLE: begin
                    pop = !fifo_empty;
                end
                S_START: begin
                    state_d   = S_DATA;
                    bit_idx_d = '0;
                end
                S_DATA: begin
                    if (bit_idx_q == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
                        if (par_mode_q != 2'd0) begin
                            state_d = S_PARITY;
                        end else begin
                            state_d    = S_STOP;
                            stop_cnt_d = STOP_LAST;
                        end
`else
                        state_d    = S_STOP;
                        stop_cnt_d = STOP_LAST;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    state_d    = S_STOP;
                    stop_cnt_d = STOP_LAST;
                end
`endif
                S_STOP: begin
                    if (stop_cnt_q != 2'd0) begin
                        stop_cnt_d = stop_cnt_q - 1'b1;
                    end else if (!fifo_empty) begin
                        pop = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
        // Loading on pop is shared by IDLE and the back-to-back path out of STOP.
        if (pop) begin
            shift_d = mem_q[rd_ptr_q];
            state_d = S_START;
`ifdef UART_TX_PARITY_EN
            par_mode_d = parity_mode;
`endif
        end
    end

    always_comb begin
        txd_d = 1'b1;
        case (state_d)
            S_IDLE:   txd_d = 1'b1;
            S_START:  txd_d = 1'b0;
            S_DATA:   txd_d = shift_d[bit_idx_d];
`ifdef UART_TX_PARITY_EN
            S_PARITY: txd_d = par_bit;
`endif
            S_STOP:   txd_d = 1'b1;
            default:  txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            bit_idx_q  <= '0;
            stop_cnt_q <= 2'd0;
            shift_q    <= '0;
            txd_q      <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_mode_q <= 2'd0;
`endif
        end else begin
            state_q    <= state_d;
            bit_idx_q  <= bit_idx_d;
            stop_cnt_q <= stop_cnt_d;
            shift_q    <= shift_d;
            txd_q      <= txd_d;
`ifdef UART_TX_PARITY_EN
            par_mode_q <= par_mode_d;
`endif
        end
    end

    assign txd        = txd_q;
    assign tbr        = !fifo_full;
    assign tx_busy    = (state_q != S_IDLE);
    assign fifo_count = count_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: default instance plus a DATA_W=7 / STOP_BITS=2 instance.
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic       baud;
    logic       wr_en, wr1;
    logic [7:0] wr_data;
    logic [6:0] wr_data1;
    logic [1:0] par;
    logic       txd, tbr, busy, ovf;
    logic [2:0] cnt;
    logic       txd1, tbr1, busy1, ovf1;
    logic [2:0] cnt1;

    int total = 0;
    int bad   = 0;

    bit seq_a5 [10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
    bit seq_41 [10] = '{0, 1, 0, 0, 0, 0, 0, 1, 1, 1};

    always #5 clk = ~clk;

    uart_tx_fifo u0 (
        .clk           (clk),
        .rst           (rst),
        .baud_t_enable (baud),
        .wr_en         (wr_en),
        .wr_data       (wr_data),
`ifdef UART_TX_PARITY_EN
        .parity_mode   (par),
`endif
        .txd           (txd),
        .tbr           (tbr),
        .tx_busy       (busy),
        .fifo_count    (cnt),
        .overflow      (ovf)
    );

    uart_tx_fifo #(.DATA_W(7), .FIFO_DEPTH(4), .STOP_BITS(2)) u1 (
        .clk           (clk),
        .rst           (rst),
        .baud_t_enable (baud),
        .wr_en         (wr1),
        .wr_data       (wr_data1),
`ifdef UART_TX_PARITY_EN
        .parity_mode   (2'b00),
`endif
        .txd           (txd1),
        .tbr           (tbr1),
        .tx_busy       (busy1),
        .fifo_count    (cnt1),
        .overflow      (ovf1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic tk();
        baud = 1'b1;
        @(posedge clk);
        #1;
        baud = 1'b0;
    endtask

    task automatic wr(input logic [7:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
    endtask

    task automatic frame_bits(input logic [8:0] d, input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            tk();
            chk(tag, txd, d[i]);
        end
    endtask

    initial begin
        rst = 1'b1; baud = 1'b0; wr_en = 1'b0; wr_data = '0;
        wr1 = 1'b0; wr_data1 = '0; par = 2'd0;
        idle(3);
        chk("rst_txd", txd, 1'b1);
        chk("rst_tbr", tbr, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_count", cnt, 3'd0);
        chk("rst_ovf", ovf, 1'b0);
        chk("rst_txd1", txd1, 1'b1);
        rst = 1'b0;
        idle(1);

        // single 0xA5 frame, ticks spaced so holds between ticks are visible
        wr(8'hA5);
        chk("a5_count", cnt, 3'd1);
        chk("a5_nobusy", busy, 1'b0);
        for (int i = 0; i < 10; i++) begin
            idle(2);
            if (i > 0) chk("a5_hold", txd, seq_a5[i-1]);
            tk();
            chk("a5_txd", txd, seq_a5[i]);
        end
        chk("a5_busy_stop", busy, 1'b1);
        tk();
        chk("a5_end_txd", txd, 1'b1);
        chk("a5_end_busy", busy, 1'b0);
        tk();
        chk("empty_tick_txd", txd, 1'b1);
        chk("empty_tick_busy", busy, 1'b0);
        chk("empty_tick_count", cnt, 3'd0);

`ifdef UART_TX_PARITY_EN
        par = 2'd1;
        wr(8'hA5);
        tk();
        chk("even_start", txd, 1'b0);
        frame_bits(9'h0A5, 8, "even_data");
        tk();
        chk("even_par", txd, 1'b0);
        tk();
        chk("even_stop", txd, 1'b1);
        chk("even_stop_busy", busy, 1'b1);
        tk();
        chk("even_end_busy", busy, 1'b0);

        par = 2'd2;
        wr(8'hA5);
        tk();
        par = 2'd1;
        chk("odd_start", txd, 1'b0);
        frame_bits(9'h0A5, 8, "odd_data");
        tk();
        chk("odd_par_latched", txd, 1'b1);
        tk();
        chk("odd_stop", txd, 1'b1);
        tk();
        chk("odd_end_busy", busy, 1'b0);

        par = 2'd3;
        wr(8'h00);
        tk();
        frame_bits(9'h000, 8, "mark_data");
        tk();
        chk("mark_par", txd, 1'b1);
        tk();
        chk("mark_stop_busy", busy, 1'b1);
        tk();
        chk("mark_end_busy", busy, 1'b0);
        par = 2'd0;
`endif

        // overflow: six writes into a four-entry FIFO
        wr(8'h01);
        chk("ovf_c1", cnt, 3'd1);
        wr(8'h02);
        chk("ovf_c2", cnt, 3'd2);
        wr(8'h03);
        chk("ovf_c3", cnt, 3'd3);
        chk("ovf_tbr3", tbr, 1'b1);
        wr(8'h04);
        chk("ovf_c4", cnt, 3'd4);
        chk("ovf_tbr4", tbr, 1'b0);
        chk("ovf_none4", ovf, 1'b0);
        wr(8'h05);
        chk("ovf_c5", cnt, 3'd4);
        chk("ovf_pulse5", ovf, 1'b1);
        wr(8'h06);
        chk("ovf_c6", cnt, 3'd4);
        chk("ovf_pulse6", ovf, 1'b1);
        idle(1);
        chk("ovf_clear", ovf, 1'b0);
        chk("ovf_c_hold", cnt, 3'd4);

        baud = 1'b1; wr_en = 1'b1; wr_data = 8'h77;
        @(posedge clk);
        #1;
        baud = 1'b0; wr_en = 1'b0;
        chk("popwr_count", cnt, 3'd4);
        chk("popwr_ovf", ovf, 1'b0);
        chk("popwr_start", txd, 1'b0);
        frame_bits(9'h001, 8, "popwr_data");
        tk();
        chk("popwr_stop", txd, 1'b1);
        tk();
        chk("popwr_next_start", txd, 1'b0);
        chk("popwr_next_count", cnt, 3'd3);

        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        chk("flush_count", cnt, 3'd0);
        chk("flush_txd", txd, 1'b1);

        // back-to-back frames
        wr(8'h55);
        wr(8'h0F);
        tk();
        chk("b2b_start1", txd, 1'b0);
        frame_bits(9'h055, 8, "b2b_data1");
        tk();
        chk("b2b_stop1", txd, 1'b1);
        tk();
        chk("b2b_start2", txd, 1'b0);
        chk("b2b_busy2", busy, 1'b1);
        frame_bits(9'h00F, 8, "b2b_data2");
        tk();
        chk("b2b_stop2", txd, 1'b1);
        tk();
        chk("b2b_end_busy", busy, 1'b0);
        chk("b2b_end_txd", txd, 1'b1);

        // reset during data bit 3 with two entries still queued
        wr(8'h33);
        wr(8'h44);
        wr(8'h55);
        tk();
        chk("rmf_start", txd, 1'b0);
        frame_bits(9'h033, 4, "rmf_data");
        chk("rmf_count", cnt, 3'd2);
        rst = 1'b1; wr_en = 1'b1; wr_data = 8'hAA;
        @(posedge clk);
        #1;
        rst = 1'b0; wr_en = 1'b0;
        chk("rmf_txd", txd, 1'b1);
        chk("rmf_cnt", cnt, 3'd0);
        chk("rmf_busy", busy, 1'b0);
        chk("rmf_tbr", tbr, 1'b1);
        for (int i = 0; i < 12; i++) begin
            tk();
            chk("rmf_quiet", txd, 1'b1);
        end
        chk("rmf_quiet_busy", busy, 1'b0);

        // DATA_W=7, STOP_BITS=2 instance
        wr1 = 1'b1; wr_data1 = 7'h41;
        @(posedge clk);
        #1;
        wr1 = 1'b0;
        chk("w7_count", cnt1, 3'd1);
        for (int i = 0; i < 10; i++) begin
            tk();
            chk("w7_txd", txd1, seq_41[i]);
        end
        chk("w7_busy_stop2", busy1, 1'b1);
        tk();
        chk("w7_end_busy", busy1, 1'b0);
        chk("w7_end_txd", txd1, 1'b1);
        chk("w7_ovf", ovf1, 1'b0);
        chk("w7_tbr", tbr1, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
